// File: rtl/flashram_cmd_engine.sv
// N64 FlashRAM command engine: decodes command-register writes, holds the page buffer
// and hands program/erase jobs to the CPU. Chip erase is built only with FLASHRAM_ERASE_ALL_EN.
module flashram_cmd_engine #(
    parameter int BUF_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    input  logic        buf_write,
    input  logic [4:0]  buf_address,
    input  logic [31:0] buf_wdata,
    output logic [31:0] status,
    output logic [1:0]  mode,
    input  logic [4:0]  flashram_address,
    output logic [31:0] flashram_rdata,
    output logic [9:0]  sector,
    output logic        operation_pending,
    output logic        write_or_erase,
    output logic        sector_or_all,
    input  logic        operation_done
);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_BUFFER      = 3'd1,
        ST_ERASE_ARMED = 3'd2,
        ST_BUSY_WRITE  = 3'd3,
        ST_BUSY_ERASE  = 3'd4
    } state_e;

    localparam logic [7:0] OP_ARRAY   = 8'hF0;
    localparam logic [7:0] OP_STATUS  = 8'hE1;
    localparam logic [7:0] OP_BUFFER  = 8'hB4;
    localparam logic [7:0] OP_PROGRAM = 8'hA5;
    localparam logic [7:0] OP_SECTOR  = 8'h4B;
    localparam logic [7:0] OP_CHIP    = 8'h3C;
    localparam logic [7:0] OP_EXEC    = 8'hD2;

    state_e      state_q, state_d, post_done_s;
    logic [1:0]  mode_q, mode_d;
    logic [9:0]  sector_q, sector_d;
    logic        wbusy_q, wbusy_d, ebusy_q, ebusy_d;
    logic        wdone_q, wdone_d, edone_q, edone_d;
    logic        woe_q, woe_d;
    logic        pend_q;
    logic [31:0] rdata_q;
    logic [7:0]  opcode_s;
    logic [31:0] mem [0:BUF_WORDS-1];
    logic        unused_s;

    assign opcode_s = cmd_data[31:24];
    assign unused_s = ^cmd_data[23:10];

`ifdef FLASHRAM_ERASE_ALL_EN
    logic soa_q, soa_d;
    assign sector_or_all = soa_q;
`else
    assign sector_or_all = 1'b0;
`endif

    // Next-state decode: completion is applied first, then the command sees the resulting state
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        sector_d = sector_q;
        wbusy_d  = wbusy_q;
        ebusy_d  = ebusy_q;
        wdone_d  = wdone_q;
        edone_d  = edone_q;
        woe_d    = woe_q;
`ifdef FLASHRAM_ERASE_ALL_EN
        soa_d    = soa_q;
`endif
        post_done_s = state_q;

        if (operation_done && (state_q == ST_BUSY_WRITE)) begin
            wbusy_d     = 1'b0;
            wdone_d     = 1'b1;
            post_done_s = ST_IDLE;
        end else if (operation_done && (state_q == ST_BUSY_ERASE)) begin
            ebusy_d     = 1'b0;
            edone_d     = 1'b1;
            post_done_s = ST_IDLE;
        end else begin
            post_done_s = state_q;
        end
        state_d = post_done_s;

        if (cmd_valid && (opcode_s == OP_STATUS)) begin
            mode_d = 2'd1;
        end else if (cmd_valid) begin
            case (post_done_s)
                ST_IDLE: begin
                    case (opcode_s)
                        OP_ARRAY:  mode_d = 2'd0;
                        OP_BUFFER: begin
                            mode_d  = 2'd2;
                            state_d = ST_BUFFER;
                        end
                        OP_SECTOR: begin
                            sector_d = cmd_data[9:0] & 10'h3F0;
`ifdef FLASHRAM_ERASE_ALL_EN
                            soa_d    = 1'b0;
`endif
                            state_d  = ST_ERASE_ARMED;
                        end
`ifdef FLASHRAM_ERASE_ALL_EN
                        OP_CHIP: begin
                            sector_d = 10'd0;
                            soa_d    = 1'b1;
                            state_d  = ST_ERASE_ARMED;
                        end
`endif
                        // Status-register write: set bits clear the matching done flags
                        OP_EXEC: begin
                            edone_d = edone_q & ~cmd_data[3];
                            wdone_d = wdone_q & ~cmd_data[2];
                        end
                        default: state_d = post_done_s;
                    endcase
                end
                ST_BUFFER: begin
                    case (opcode_s)
                        OP_ARRAY: begin
                            mode_d  = 2'd0;
                            state_d = ST_IDLE;
                        end
                        OP_PROGRAM: begin
                            sector_d = cmd_data[9:0];
                            woe_d    = 1'b0;
`ifdef FLASHRAM_ERASE_ALL_EN
                            soa_d    = 1'b0;
`endif
                            wbusy_d  = 1'b1;
                            wdone_d  = 1'b0;
                            state_d  = ST_BUSY_WRITE;
                        end
                        default: state_d = post_done_s;
                    endcase
                end
                ST_ERASE_ARMED: begin
                    case (opcode_s)
                        OP_EXEC: begin
                            woe_d   = 1'b1;
                            ebusy_d = 1'b1;
                            edone_d = 1'b0;
                            state_d = ST_BUSY_ERASE;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
                default: state_d = post_done_s;
            endcase
        end else begin
            mode_d = mode_q;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'd0;
            sector_q <= 10'd0;
            wbusy_q  <= 1'b0;
            ebusy_q  <= 1'b0;
            wdone_q  <= 1'b0;
            edone_q  <= 1'b0;
            woe_q    <= 1'b0;
            pend_q   <= 1'b0;
`ifdef FLASHRAM_ERASE_ALL_EN
            soa_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            sector_q <= sector_d;
            wbusy_q  <= wbusy_d;
            ebusy_q  <= ebusy_d;
            wdone_q  <= wdone_d;
            edone_q  <= edone_d;
            woe_q    <= woe_d;
            pend_q   <= (state_d == ST_BUSY_WRITE) || (state_d == ST_BUSY_ERASE);
`ifdef FLASHRAM_ERASE_ALL_EN
            soa_q    <= soa_d;
`endif
        end
    end

    // Page buffer storage; deliberately not reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (buf_write && (state_q == ST_BUFFER)) begin
            mem[buf_address] <= buf_wdata;
        end
    end

    // Registered CPU read port
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= 32'd0;
        end else begin
            rdata_q <= mem[flashram_address];
        end
    end

    assign status            = {28'd0, edone_q, wdone_q, ebusy_q, wbusy_q};
    assign mode              = mode_q;
    assign sector            = sector_q;
    assign operation_pending = pend_q;
    assign write_or_erase    = woe_q;
    assign flashram_rdata    = rdata_q;

endmodule

// File: tb/tb_flashram_cmd_engine.sv
// Directed scoreboard bench for flashram_cmd_engine; honours FLASHRAM_ERASE_ALL_EN when defined.
module tb_flashram_cmd_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        buf_write;
    logic [4:0]  buf_address;
    logic [31:0] buf_wdata;
    logic [31:0] status;
    logic [1:0]  mode;
    logic [4:0]  flashram_address;
    logic [31:0] flashram_rdata;
    logic [9:0]  sector;
    logic        operation_pending;
    logic        write_or_erase;
    logic        sector_or_all;
    logic        operation_done;

    int vectors = 0;
    int miscompares = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    flashram_cmd_engine #(.BUF_WORDS(32)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .buf_write(buf_write), .buf_address(buf_address), .buf_wdata(buf_wdata),
        .status(status), .mode(mode), .flashram_address(flashram_address),
        .flashram_rdata(flashram_rdata), .sector(sector),
        .operation_pending(operation_pending), .write_or_erase(write_or_erase),
        .sector_or_all(sector_or_all), .operation_done(operation_done)
    );

    task automatic expect_v(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check_v(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                miscompares++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [31:0] d);
        cmd_valid = 1'b1;
        cmd_data  = d;
        step();
        cmd_valid = 1'b0;
        cmd_data  = 32'd0;
    endtask

    task automatic done_pulse();
        operation_done = 1'b1;
        step();
        operation_done = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1; cmd_valid = 1'b0; cmd_data = 32'd0; buf_write = 1'b0;
        buf_address = 5'd0; buf_wdata = 32'd0; flashram_address = 5'd0; operation_done = 1'b0;
        #3 reset_n = 1'b0;
        step(); step();
        expect_v("rst_status", 32'd0); check_v(status);
        expect_v("rst_mode", 32'd0);   check_v({30'd0, mode});
        expect_v("rst_sector", 32'd0); check_v({22'd0, sector});
        expect_v("rst_pend", 32'd0);   check_v({31'd0, operation_pending});
        expect_v("rst_woe", 32'd0);    check_v({31'd0, write_or_erase});
        expect_v("rst_soa", 32'd0);    check_v({31'd0, sector_or_all});
        expect_v("rst_rdata", 32'd0);  check_v(flashram_rdata);
        reset_n = 1'b1;
        step();

        // Fill the page buffer
        expect_v("b4_mode", 32'd2);
        cmd(32'hB400_0000);
        check_v({30'd0, mode});
        for (int i = 0; i < 32; i++) begin
            buf_write = 1'b1; buf_address = i[4:0]; buf_wdata = 32'hA000_0000 + i;
            step();
        end
        buf_write = 1'b0;
        flashram_address = 5'd5;

        expect_v("a5_sector", 32'h123); expect_v("a5_woe", 32'd0);
        expect_v("a5_pend", 32'd1);     expect_v("a5_status", 32'h1);
        expect_v("a5_rdata5", 32'hA000_0005);
        cmd(32'hA500_0123);
        check_v({22'd0, sector}); check_v({31'd0, write_or_erase});
        check_v({31'd0, operation_pending}); check_v(status); check_v(flashram_rdata);

        // Busy: buffer writes dropped, only 0xE1 honoured
        buf_write = 1'b1; buf_address = 5'd5; buf_wdata = 32'hDEAD_BEEF;
        step();
        buf_write = 1'b0;
        step();
        expect_v("busy_drop_wr", 32'hA000_0005); check_v(flashram_rdata);
        expect_v("busy_f0_mode", 32'd2);
        cmd(32'hF000_0000);
        check_v({30'd0, mode});
        expect_v("busy_e1_mode", 32'd1); expect_v("busy_e1_pend", 32'd1);
        cmd(32'hE100_0000);
        check_v({30'd0, mode}); check_v({31'd0, operation_pending});

        expect_v("wdone_pend", 32'd0); expect_v("wdone_status", 32'h4); expect_v("wdone_mode", 32'd1);
        done_pulse();
        check_v({31'd0, operation_pending}); check_v(status); check_v({30'd0, mode});

        expect_v("clr_wdone", 32'd0);
        cmd(32'hD200_0004);
        check_v(status);

        // Sector erase
        expect_v("4b_sector", 32'h020); expect_v("4b_soa", 32'd0); expect_v("4b_pend", 32'd0);
        cmd(32'h4B00_002F);
        check_v({22'd0, sector}); check_v({31'd0, sector_or_all}); check_v({31'd0, operation_pending});
        expect_v("d2_woe", 32'd1); expect_v("d2_status", 32'h2); expect_v("d2_pend", 32'd1);
        cmd(32'hD200_0000);
        check_v({31'd0, write_or_erase}); check_v(status); check_v({31'd0, operation_pending});
        expect_v("edone_status", 32'h8); expect_v("edone_pend", 32'd0);
        done_pulse();
        check_v(status); check_v({31'd0, operation_pending});
        expect_v("idle_done_status", 32'h8); expect_v("idle_done_pend", 32'd0);
        done_pulse();
        check_v(status); check_v({31'd0, operation_pending});

        // Chip erase
`ifdef FLASHRAM_ERASE_ALL_EN
        expect_v("3c_soa", 32'd1); expect_v("3c_sector", 32'd0);
        cmd(32'h3C00_0000);
        check_v({31'd0, sector_or_all}); check_v({22'd0, sector});
        expect_v("chip_pend", 32'd1); expect_v("chip_status", 32'h2);
        cmd(32'hD200_0000);
        check_v({31'd0, operation_pending}); check_v(status);
        done_pulse();
`else
        expect_v("3c_soa", 32'd0); expect_v("3c_sector", 32'h020);
        cmd(32'h3C00_0000);
        check_v({31'd0, sector_or_all}); check_v({22'd0, sector});
        expect_v("chip_pend", 32'd0); expect_v("chip_status", 32'h8);
        cmd(32'hD200_0000);
        check_v({31'd0, operation_pending}); check_v(status);
`endif

        // Illegal opcode while armed drops back to IDLE
        cmd(32'h4B00_0010);
        cmd(32'hB400_0000);
        expect_v("armed_ill_pend", 32'd0); expect_v("armed_ill_mode", 32'd1);
        expect_v("armed_ill_status", 32'h8);
        cmd(32'hD200_0000);
        check_v({31'd0, operation_pending}); check_v({30'd0, mode}); check_v(status);

        // operation_done and a command in the same cycle
        cmd(32'hB400_0000);
        expect_v("a5b_status", 32'h9); expect_v("a5b_woe", 32'd0);
        cmd(32'hA500_0007);
        check_v(status); check_v({31'd0, write_or_erase});
        expect_v("sim_mode", 32'd2); expect_v("sim_pend", 32'd0); expect_v("sim_status", 32'hC);
        operation_done = 1'b1; cmd_valid = 1'b1; cmd_data = 32'hB400_0000;
        step();
        operation_done = 1'b0; cmd_valid = 1'b0; cmd_data = 32'd0;
        check_v({30'd0, mode}); check_v({31'd0, operation_pending}); check_v(status);

        // Write visible on the read port one cycle after it is stored
        buf_write = 1'b1; buf_address = 5'd4; buf_wdata = 32'h1234_5678; flashram_address = 5'd4;
        expect_v("rd_old", 32'hA000_0004);
        step();
        buf_write = 1'b0;
        check_v(flashram_rdata);
        expect_v("rd_new", 32'h1234_5678);
        step();
        check_v(flashram_rdata);

        // Reset in the middle of an erase
        cmd(32'hF000_0000);
        cmd(32'h4B00_0040);
        expect_v("pre_rst_pend", 32'd1); expect_v("pre_rst_status", 32'h6);
        cmd(32'hD200_0000);
        check_v({31'd0, operation_pending}); check_v(status);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        expect_v("mid_rst_pend", 32'd0);   check_v({31'd0, operation_pending});
        expect_v("mid_rst_status", 32'd0); check_v(status);
        expect_v("mid_rst_sector", 32'd0); check_v({22'd0, sector});
        expect_v("mid_rst_woe", 32'd0);    check_v({31'd0, write_or_erase});
        expect_v("mid_rst_rdata", 32'd0);  check_v(flashram_rdata);
        step();
        reset_n = 1'b1;
        step();
        expect_v("post_rst_done_status", 32'd0); expect_v("post_rst_done_pend", 32'd0);
        done_pulse();
        check_v(status); check_v({31'd0, operation_pending});

        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end else begin
            vectors = vectors + 0;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/flashram_cmd_engine.md
FLASHRAM_CMD_ENGINE -- requirements
Module: flashram_cmd_engine

Interface
REQ-001 SHALL expose parameter BUF_WORDS, default 32, meaning page buffer depth in 32-bit words (128-byte page).
REQ-002 SHALL have one clock and an asynchronous active-low reset, with these ports: clk  in  1  system clock; reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have port cmd_valid  in  1  single-cycle pulse marking an N64 write to the command register.
REQ-004 SHALL have port cmd_data  in  32  command word: [31:24] opcode, [9:0] sector/page argument.
REQ-005 SHALL have ports buf_write  in  1, buf_address  in  5, buf_wdata  in  32  N64 page-buffer write.
REQ-006 SHALL have port status  out  32  N64-visible status: [3] erase_done, [2] write_done, [1] erase_busy, [0] write_busy, other bits 0.
REQ-007 SHALL have port mode  out  2  N64 read mode: 0 array, 1 status, 2 buffer.
REQ-008 SHALL have ports flashram_address  in  5 and flashram_rdata  out  32  CPU read of the page buffer.
REQ-009 SHALL have ports sector  out  10, operation_pending  out  1, write_or_erase  out  1 (1 = erase), sector_or_all  out  1 (1 = whole chip), operation_done  in  1 (single-cycle pulse from CPU).

Function
REQ-010 SHALL implement FSM states IDLE, BUFFER, ERASE_ARMED, BUSY_WRITE, BUSY_ERASE; the reset state SHALL be IDLE.
REQ-011 On opcode 0xF0 in IDLE or BUFFER, SHALL set mode=0 and go to IDLE.
REQ-012 On opcode 0xE1 in any state, SHALL set mode=1 and leave the FSM state unchanged.
REQ-013 On opcode 0xB4 in IDLE, SHALL set mode=2 and go to BUFFER.
REQ-014 In BUFFER, buf_write SHALL store buf_wdata at buf_address, with the write visible on flashram_rdata the cycle after it is stored.
REQ-015 On opcode 0xA5 in BUFFER, SHALL latch sector=cmd_data[9:0], write_or_erase=0, sector_or_all=0, set write_busy, clear write_done, and go to BUSY_WRITE.
REQ-016 On opcode 0x4B in IDLE, SHALL latch sector=cmd_data[9:0] & 10'h3F0 (16-page aligned), sector_or_all=0, and go to ERASE_ARMED.
REQ-017 On opcode 0x3C in IDLE, SHALL set sector=0, sector_or_all=1, and go to ERASE_ARMED.
REQ-018 On opcode 0xD2 in ERASE_ARMED, SHALL set write_or_erase=1, set erase_busy, clear erase_done, and go to BUSY_ERASE.
REQ-019 operation_pending SHALL be registered high exactly while the FSM is in BUSY_WRITE or BUSY_ERASE, rising the cycle after the entering command.
REQ-020 On operation_done in BUSY_WRITE, SHALL clear write_busy, set write_done, and go to IDLE with mode unchanged.
REQ-021 On operation_done in BUSY_ERASE, SHALL clear erase_busy, set erase_done, and go to IDLE.
REQ-022 operation_done outside the BUSY states SHALL be ignored.
REQ-023 In BUSY states, SHALL ignore all commands except 0xE1, and SHALL drop buf_write.
REQ-024 Opcodes not legal in the current state SHALL be ignored; an illegal opcode in ERASE_ARMED SHALL return the FSM to IDLE.
REQ-025 If cmd_valid and operation_done occur in the same cycle, SHALL apply operation_done first, then decode the command against the resulting state.
REQ-026 A status register write (opcode 0xD2 in IDLE) with cmd_data[3:2] set SHALL clear the corresponding done bits.
REQ-027 flashram_rdata SHALL be registered with 1-cycle latency from flashram_address, and flashram_address[4:0] SHALL wrap naturally.
REQ-028 The buffer SHALL NOT be cleared by reset or by commands; its contents after power-up are undefined.

Reset
REQ-029 Assertion of reset_n low SHALL asynchronously force: state=IDLE, mode=0, status=0, sector=0, operation_pending=0, write_or_erase=0, sector_or_all=0, flashram_rdata=0.
REQ-030 Reset during a BUSY state SHALL abort the operation without requiring operation_done.

Configuration
REQ-031 SHALL define macro FLASHRAM_ERASE_ALL_EN as the chip-erase compile option.
REQ-032 With FLASHRAM_ERASE_ALL_EN defined, opcode 0x3C SHALL behave per REQ-017.
REQ-033 Without FLASHRAM_ERASE_ALL_EN, opcode 0x3C SHALL be ignored and sector_or_all SHALL be tied to 0.

Verification
REQ-034 Buffer write: cmd 0xB4000000; buf words 0..31 = 0xA0000000+i; cmd 0xA5000123 -> sector=0x123, write_or_erase=0, operation_pending=1 next cycle, status=0x1, flashram_rdata at address 5 = 0xA0000005.
REQ-035 Write completion: operation_done pulse during BUSY_WRITE -> operation_pending=0 next cycle, status=0x4.
REQ-036 Sector erase: cmd 0x4B00002F then 0xD2000000 -> sector=0x020, sector_or_all=0, write_or_erase=1, status=0x2; after operation_done -> status=0x8.
REQ-037 Chip erase: cmd 0x3C000000 then 0xD2000000 -> sector_or_all=1 with FLASHRAM_ERASE_ALL_EN; without the macro -> no pending operation, state stays IDLE.
REQ-038 Simultaneous events: operation_done and cmd 0xB4000000 in the same cycle while BUSY_WRITE -> state BUFFER, mode=2.
REQ-039 Reset mid-operation: reset_n low during BUSY_ERASE -> all outputs 0 immediately; a later operation_done is ignored.
